// File: rtl/pipeline_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stage_ctrl
//
// Front-end pipeline register controller. Applies the hazard unit's
// stall/flush decisions to the PC and the IF/ID and ID/EX instruction
// registers, registers one-cycle bubble strobes for EX/MEM and MEM/WB, and
// keeps saturating stall/flush statistics plus a sticky stall watchdog.
//
// Every cycle is exactly one mode, highest priority first:
//   FLUSH : i_PCSrc=1                  -> redirect, squash IF/ID and ID/EX
//   STALL : i_PCSrc=0, i_PC_Write=1    -> freeze PC and IF/ID, optional ID/EX bubble
//   RUN   : i_PCSrc=0, i_PC_Write=0    -> advance PC by 4, shift the pipe
//
// Ports
//   i_Clk                rising-edge clock
//   i_Reset_n            asynchronous active-low reset
//   i_PCSrc              branch/jump taken, redirect fetch
//   i_Branch_Target      redirect address (used unmodified)
//   i_IF_ID_Signal       hazard unit IF/ID control (IF/ID always holds on STALL)
//   i_ID_EX_Signal       on STALL: 1 = ID/EX holds, 0 = ID/EX takes a bubble
//   i_EX_MEM_Signal      bubble request for EX/MEM (registered to o_EXMEM_Bubble)
//   i_MEM_WB_Signal      bubble request for MEM/WB (registered to o_MEMWB_Bubble)
//   i_PC_Write           1 = freeze PC (stall)
//   i_IMem_Instruction   instruction word fetched at o_PC
//   i_Clear_Counters     synchronous clear of statistics and watchdog
//   o_PC                 current fetch address
//   o_IFID_*             IF/ID instruction, PC and valid
//   o_IDEX_*             ID/EX instruction, PC and valid
//   o_EXMEM_Bubble       registered EX/MEM bubble strobe
//   o_MEMWB_Bubble       registered MEM/WB bubble strobe
//   o_Stall_Count        saturating count of STALL cycles
//   o_Flush_Count        saturating count of FLUSH cycles
//   o_Stall_Timeout      sticky flag: MAX_STALL consecutive stalls seen
// -----------------------------------------------------------------------------
module pipeline_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP       = 32'h0000_0000,
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_PCSrc,
    input  logic [31:0]      i_Branch_Target,
    input  logic             i_IF_ID_Signal,
    input  logic             i_ID_EX_Signal,
    input  logic             i_EX_MEM_Signal,
    input  logic             i_MEM_WB_Signal,
    input  logic             i_PC_Write,
    input  logic [31:0]      i_IMem_Instruction,
    input  logic             i_Clear_Counters,
    output logic [31:0]      o_PC,
    output logic [31:0]      o_IFID_Instruction,
    output logic [31:0]      o_IFID_PC,
    output logic             o_IFID_Valid,
    output logic [31:0]      o_IDEX_Instruction,
    output logic [31:0]      o_IDEX_PC,
    output logic             o_IDEX_Valid,
    output logic             o_EXMEM_Bubble,
    output logic             o_MEMWB_Bubble,
    output logic [CNT_W-1:0] o_Stall_Count,
    output logic [CNT_W-1:0] o_Flush_Count,
    output logic             o_Stall_Timeout
);

    // Cycle modes
    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_STALL = 2'd1;
    localparam logic [1:0] MODE_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [7:0]       RUN_SAT  = 8'(MAX_STALL);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_instr;
    logic [31:0]      r_ifid_pc;
    logic             r_ifid_valid;
    logic [31:0]      r_idex_instr;
    logic [31:0]      r_idex_pc;
    logic             r_idex_valid;
    logic             r_exmem_bubble;
    logic             r_memwb_bubble;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [7:0]       r_stall_run;
    logic             r_stall_timeout;

    // -------------------------------------------------------------------------
    // Mode decode
    // -------------------------------------------------------------------------
    logic [1:0] w_mode;
    logic       w_is_flush;
    logic       w_is_stall;
    logic       w_is_run;
    logic       w_ifid_hold;
    logic [7:0] w_stall_run_inc;

    always_comb begin
        w_mode = MODE_RUN;
        if (i_PCSrc) begin
            w_mode = MODE_FLUSH;
        end else if (i_PC_Write) begin
            w_mode = MODE_STALL;
        end
    end

    assign w_is_flush = (w_mode == MODE_FLUSH);
    assign w_is_stall = (w_mode == MODE_STALL);
    assign w_is_run   = (w_mode == MODE_RUN);

    // The hazard unit's IF/ID request is overridden: a frozen PC always
    // implies a frozen IF/ID, otherwise the held fetch word would be lost.
    assign w_ifid_hold = w_is_stall & (i_IF_ID_Signal | 1'b1);

    // Watchdog run length after this cycle's stall, saturating at MAX_STALL.
    assign w_stall_run_inc = (r_stall_run == RUN_SAT) ? RUN_SAT
                                                      : r_stall_run + 8'd1;

    // -------------------------------------------------------------------------
    // Program counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_pc <= RESET_PC;
        end else if (w_is_flush) begin
            r_pc <= i_Branch_Target;
        end else if (w_is_run) begin
            r_pc <= r_pc + 32'd4;   // wraps naturally at 2^32
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_ifid_instr <= NOP;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_is_flush) begin
            r_ifid_instr <= NOP;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (!w_ifid_hold) begin
            r_ifid_instr <= i_IMem_Instruction;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // ID/EX register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_idex_instr <= NOP;
            r_idex_pc    <= '0;
            r_idex_valid <= 1'b0;
        end else if (w_is_flush || (w_is_stall && !i_ID_EX_Signal)) begin
            // Squash on flush; bubble on a stall that does not hold ID/EX.
            r_idex_instr <= NOP;
            r_idex_pc    <= '0;
            r_idex_valid <= 1'b0;
        end else if (w_is_run) begin
            r_idex_instr <= r_ifid_instr;
            r_idex_pc    <= r_ifid_pc;
            r_idex_valid <= r_ifid_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Downstream bubble strobes (independent of mode)
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_exmem_bubble <= 1'b0;
            r_memwb_bubble <= 1'b0;
        end else begin
            r_exmem_bubble <= i_EX_MEM_Signal;
            r_memwb_bubble <= i_MEM_WB_Signal;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (i_Clear_Counters) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_is_stall && (r_stall_cnt != CNT_SAT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_is_flush && (r_flush_cnt != CNT_SAT)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stall watchdog
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_stall_run     <= '0;
            r_stall_timeout <= 1'b0;
        end else if (i_Clear_Counters) begin
            r_stall_run     <= '0;
            r_stall_timeout <= 1'b0;
        end else if (w_is_stall) begin
            r_stall_run <= w_stall_run_inc;
            // Flag on the same edge that completes the MAX_STALL-th stall.
            if (w_stall_run_inc == RUN_SAT) begin
                r_stall_timeout <= 1'b1;
            end
        end else begin
            r_stall_run <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_PC               = r_pc;
    assign o_IFID_Instruction = r_ifid_instr;
    assign o_IFID_PC          = r_ifid_pc;
    assign o_IFID_Valid       = r_ifid_valid;
    assign o_IDEX_Instruction = r_idex_instr;
    assign o_IDEX_PC          = r_idex_pc;
    assign o_IDEX_Valid       = r_idex_valid;
    assign o_EXMEM_Bubble     = r_exmem_bubble;
    assign o_MEMWB_Bubble     = r_memwb_bubble;
    assign o_Stall_Count      = r_stall_cnt;
    assign o_Flush_Count      = r_flush_cnt;
    assign o_Stall_Timeout    = r_stall_timeout;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_stage_ctrl (CNT_W=4 so saturation is reachable,
// MAX_STALL=8, NOP set to a non-zero word so squashes are distinguishable).
// -----------------------------------------------------------------------------
module tb_pipeline_stage_ctrl;

    localparam logic [31:0] T_NOP     = 32'h0000_0013;
    localparam int          T_MAXST   = 8;
    localparam int          T_CNTW    = 4;
    localparam int          T_CNTMAX  = (1 << T_CNTW) - 1;

    typedef struct {
        logic        pcsrc;
        logic [31:0] tgt;
        logic        ifs;
        logic        ids;
        logic        exm;
        logic        mwb;
        logic        pcw;
        logic [31:0] imem;
        logic        clr;
    } in_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifi;
        logic [31:0] ifp;
        logic        ifv;
        logic [31:0] idi;
        logic [31:0] idp;
        logic        idv;
        logic        exb;
        logic        mwb;
        int          sc;
        int          fc;
        logic        to;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pcsrc, ifs, ids, exm, mwbs, pcw, clr;
    logic [31:0]       tgt, imem;
    logic [31:0]       pc, ifid_i, ifid_p, idex_i, idex_p;
    logic              ifid_v, idex_v, exb, mwb, tmo;
    logic [T_CNTW-1:0] scnt, fcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_stage_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .NOP       (T_NOP),
        .MAX_STALL (T_MAXST),
        .CNT_W     (T_CNTW)
    ) dut (
        .i_Clk              (clk),
        .i_Reset_n          (rst_n),
        .i_PCSrc            (pcsrc),
        .i_Branch_Target    (tgt),
        .i_IF_ID_Signal     (ifs),
        .i_ID_EX_Signal     (ids),
        .i_EX_MEM_Signal    (exm),
        .i_MEM_WB_Signal    (mwbs),
        .i_PC_Write         (pcw),
        .i_IMem_Instruction (imem),
        .i_Clear_Counters   (clr),
        .o_PC               (pc),
        .o_IFID_Instruction (ifid_i),
        .o_IFID_PC          (ifid_p),
        .o_IFID_Valid       (ifid_v),
        .o_IDEX_Instruction (idex_i),
        .o_IDEX_PC          (idex_p),
        .o_IDEX_Valid       (idex_v),
        .o_EXMEM_Bubble     (exb),
        .o_MEMWB_Bubble     (mwb),
        .o_Stall_Count      (scnt),
        .o_Flush_Count      (fcnt),
        .o_Stall_Timeout    (tmo)
    );

    // ---------------------------------------------------------------- checks
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".pc"},   pc,     e.pc);
        chk({tag, ".ifi"},  ifid_i, e.ifi);
        chk({tag, ".ifp"},  ifid_p, e.ifp);
        chk({tag, ".ifv"},  32'(ifid_v), 32'(e.ifv));
        chk({tag, ".idi"},  idex_i, e.idi);
        chk({tag, ".idp"},  idex_p, e.idp);
        chk({tag, ".idv"},  32'(idex_v), 32'(e.idv));
        chk({tag, ".exb"},  32'(exb), 32'(e.exb));
        chk({tag, ".mwb"},  32'(mwb), 32'(e.mwb));
        chk({tag, ".sc"},   32'(scnt), 32'(e.sc));
        chk({tag, ".fc"},   32'(fcnt), 32'(e.fc));
        chk({tag, ".to"},   32'(tmo), 32'(e.to));
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.pc = 32'h0; e.ifi = T_NOP; e.ifp = 32'h0; e.ifv = 1'b0;
        e.idi = T_NOP; e.idp = 32'h0; e.idv = 1'b0;
        e.exb = 1'b0; e.mwb = 1'b0; e.sc = 0; e.fc = 0; e.to = 1'b0;
        return e;
    endfunction

    // ------------------------------------------------------ reference model
    // Pipeline contents as plain records, counters as unbounded ints clipped
    // with min(), watchdog as a count of consecutive stall cycles.
    exp_t m;
    int   m_stall_len;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m = reset_exp();
        m_stall_len = 0;
    endtask

    task automatic model_cycle(input in_t x);
        exp_t n;
        n = m;
        if (x.pcsrc) begin
            n.pc = x.tgt;
            n.ifi = T_NOP; n.ifp = 0; n.ifv = 0;
            n.idi = T_NOP; n.idp = 0; n.idv = 0;
            n.fc = imin(m.fc + 1, T_CNTMAX);
            m_stall_len = 0;
        end else if (x.pcw) begin
            if (!x.ids) begin
                n.idi = T_NOP; n.idp = 0; n.idv = 0;
            end
            n.sc = imin(m.sc + 1, T_CNTMAX);
            m_stall_len++;
            if (m_stall_len >= T_MAXST) n.to = 1'b1;
        end else begin
            n.idi = m.ifi; n.idp = m.ifp; n.idv = m.ifv;
            n.ifi = x.imem; n.ifp = m.pc; n.ifv = 1'b1;
            n.pc = m.pc + 32'd4;
            m_stall_len = 0;
        end
        n.exb = x.exm;
        n.mwb = x.mwb;
        if (x.clr) begin
            n.sc = 0; n.fc = 0; n.to = 1'b0;
            m_stall_len = 0;
        end
        m = n;
    endtask

    // -------------------------------------------------------------- driving
    task automatic drive(input in_t x);
        pcsrc = x.pcsrc; tgt = x.tgt; ifs = x.ifs; ids = x.ids;
        exm = x.exm; mwbs = x.mwb; pcw = x.pcw; imem = x.imem; clr = x.clr;
    endtask

    task automatic step(input in_t x);
        drive(x);
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk_in(input logic pcsrc_, input logic [31:0] tgt_,
                                  input logic pcw_, input logic ids_,
                                  input logic [31:0] imem_, input logic clr_);
        in_t x;
        x.pcsrc = pcsrc_; x.tgt = tgt_; x.ifs = 1'b0; x.ids = ids_;
        x.exm = 1'b0; x.mwb = 1'b0; x.pcw = pcw_; x.imem = imem_; x.clr = clr_;
        return x;
    endfunction

    task automatic do_reset();
        drive(mk_in(0, 0, 0, 0, 32'h0, 0));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mkv(input in_t x,
                                 input logic [31:0] pc_, input logic [31:0] ifi_,
                                 input logic [31:0] ifp_, input logic ifv_,
                                 input logic [31:0] idi_, input logic [31:0] idp_,
                                 input logic idv_, input int sc_, input int fc_,
                                 input logic to_);
        vec_t v;
        v.i = x;
        v.e.pc = pc_; v.e.ifi = ifi_; v.e.ifp = ifp_; v.e.ifv = ifv_;
        v.e.idi = idi_; v.e.idp = idp_; v.e.idv = idv_;
        v.e.exb = x.exm; v.e.mwb = x.mwb;
        v.e.sc = sc_; v.e.fc = fc_; v.e.to = to_;
        return v;
    endfunction

    // -------------------------------------------------------------- watchdog
    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------- main test
    initial begin
        localparam logic [31:0] A = 32'hA000_0001, B = 32'hB000_0002,
                                C = 32'hC000_0003, D = 32'hD000_0004,
                                E = 32'hE000_0005, F = 32'hF000_0006,
                                G = 32'h6000_0007;
        vec_t tbl[$];
        in_t  x;
        exp_t e;

        rst_n = 1'b1;
        drive(mk_in(0, 0, 0, 0, 32'h0, 0));

        // ---- directed table (expectations written out by hand)
        x = mk_in(0, 0, 0, 0, A, 0); x.exm = 1;
        tbl.push_back(mkv(x, 32'h4, A, 32'h0, 1, T_NOP, 32'h0, 0, 0, 0, 0));
        x = mk_in(0, 0, 0, 0, B, 0); x.mwb = 1;
        tbl.push_back(mkv(x, 32'h8, B, 32'h4, 1, A, 32'h0, 1, 0, 0, 0));
        x = mk_in(0, 0, 0, 1, C, 0); x.ifs = 1; x.exm = 1; x.mwb = 1;
        tbl.push_back(mkv(x, 32'hC, C, 32'h8, 1, B, 32'h4, 1, 0, 0, 0));
        x = mk_in(0, 0, 1, 0, D, 0);
        tbl.push_back(mkv(x, 32'hC, C, 32'h8, 1, T_NOP, 32'h0, 0, 1, 0, 0));
        x = mk_in(0, 0, 0, 0, D, 0);
        tbl.push_back(mkv(x, 32'h10, D, 32'hC, 1, C, 32'h8, 1, 1, 0, 0));
        x = mk_in(0, 0, 1, 1, E, 0);
        tbl.push_back(mkv(x, 32'h10, D, 32'hC, 1, C, 32'h8, 1, 2, 0, 0));
        x = mk_in(1, 32'h100, 1, 1, E, 0);
        tbl.push_back(mkv(x, 32'h100, T_NOP, 32'h0, 0, T_NOP, 32'h0, 0, 2, 1, 0));
        x = mk_in(0, 0, 0, 0, E, 0);
        tbl.push_back(mkv(x, 32'h104, E, 32'h100, 1, T_NOP, 32'h0, 0, 2, 1, 0));
        for (int k = 1; k <= 9; k++) begin
            x = mk_in(0, 0, 1, 1, F, 0); x.ifs = k[0];
            tbl.push_back(mkv(x, 32'h104, E, 32'h100, 1, T_NOP, 32'h0, 0,
                              2 + k, 1, (k >= T_MAXST)));
        end
        x = mk_in(0, 0, 0, 0, F, 0);
        tbl.push_back(mkv(x, 32'h108, F, 32'h104, 1, E, 32'h100, 1, 11, 1, 1));
        x = mk_in(0, 0, 0, 0, G, 1);
        tbl.push_back(mkv(x, 32'h10C, G, 32'h108, 1, F, 32'h104, 1, 0, 0, 0));
        x = mk_in(0, 0, 1, 1, A, 1);
        tbl.push_back(mkv(x, 32'h10C, G, 32'h108, 1, F, 32'h104, 1, 0, 0, 0));
        for (int k = 1; k <= 8; k++) begin
            x = mk_in(0, 0, 1, 1, A, 0);
            tbl.push_back(mkv(x, 32'h10C, G, 32'h108, 1, F, 32'h104, 1,
                              k, 0, (k == T_MAXST)));
        end

        do_reset();
        check_outs("reset", reset_exp());
        foreach (tbl[n]) begin
            step(tbl[n].i);
            check_outs($sformatf("tbl%0d", n), tbl[n].e);
        end

        // ---- flush counter saturation
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(mk_in(1, 32'h200 + 32'(k * 16), 0, 0, 32'h0, 0));
            chk($sformatf("flushsat%0d", k), 32'(fcnt), 32'(imin(k, 15)));
        end
        chk("flushsat.pc", pc, 32'h200 + 32'(20 * 16));

        // ---- PC wrap at the top of the address space
        step(mk_in(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0));
        chk("wrap.pc0", pc, 32'hFFFF_FFFC);
        step(mk_in(0, 0, 0, 0, 32'h1234_5678, 0));
        chk("wrap.pc", pc, 32'h0);
        chk("wrap.ifp", ifid_p, 32'hFFFF_FFFC);
        chk("wrap.ifi", ifid_i, 32'h1234_5678);

        // ---- flush clears the watchdog run length
        do_reset();
        for (int k = 0; k < 5; k++) step(mk_in(0, 0, 1, 1, 32'h0, 0));
        step(mk_in(1, 32'h40, 1, 1, 32'h0, 0));
        for (int k = 0; k < 5; k++) step(mk_in(0, 0, 1, 1, 32'h0, 0));
        chk("wd_flushclr.to", 32'(tmo), 32'h0);
        chk("wd_flushclr.sc", 32'(scnt), 32'd10);

        // ---- asynchronous reset in the middle of a stall with redirect pending
        do_reset();
        for (int k = 0; k < 3; k++) step(mk_in(0, 0, 0, 0, B, 0));
        step(mk_in(0, 0, 1, 1, C, 0));
        step(mk_in(0, 0, 1, 1, C, 0));
        x = mk_in(1, 32'h200, 1, 1, C, 0); x.exm = 1; x.mwb = 1;
        drive(x);
        #2;                      // mid-cycle, no clock edge involved
        rst_n = 1'b0;
        #1;
        check_outs("asyncrst", reset_exp());
        @(posedge clk);
        #1;
        check_outs("rst_held", reset_exp());
        rst_n = 1'b1;
        step(mk_in(0, 0, 0, 0, D, 0));
        chk("postrst.pc", pc, 32'h4);
        chk("postrst.ifi", ifid_i, D);

        // ---- randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit heavy;
            heavy = ((n / 100) % 2) == 1;
            x.pcsrc = ($urandom_range(0, 9) == 0);
            x.tgt   = $urandom();
            x.ifs   = $urandom_range(0, 1);
            x.ids   = $urandom_range(0, 1);
            x.exm   = $urandom_range(0, 1);
            x.mwb   = $urandom_range(0, 1);
            x.pcw   = heavy ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 2) == 0);
            x.imem  = $urandom();
            x.clr   = ($urandom_range(0, 59) == 0);
            if (n == 500) x.tgt = 32'hFFFF_FFF8;
            model_cycle(x);
            step(x);
            e = m;
            check_outs($sformatf("rnd%0d", n), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_ctrl.md
# pipeline_stage_ctrl

Front-end pipeline register controller that consumes the hazard unit's stall/flush decisions. Owns the PC, the IF/ID and ID/EX instruction registers, and the one-cycle bubble strobes for EX/MEM and MEM/WB. Adds a stall watchdog and saturating stall/flush statistics counters. Sits between instruction memory, the hazard unit and the decode/execute stages.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP, 32'h0000_0000, instruction word inserted on flush or bubble
- MAX_STALL, 8, consecutive stall cycles that trip the watchdog (range 1..255)
- CNT_W, 16, width of the statistics counters
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- PCSrc  in  1  branch/jump taken, redirect fetch
- Branch_Target  in  32  redirect address, used when PCSrc=1
- IF_ID_Signal  in  1  hazard unit IF/ID control
- ID_EX_Signal  in  1  hazard unit ID/EX control
- EX_MEM_Signal  in  1  request bubble into EX/MEM
- MEM_WB_Signal  in  1  request bubble into MEM/WB
- PC_Write  in  1  1 = freeze PC (stall)
- IMem_Instruction  in  32  word fetched at PC
- Clear_Counters  in  1  synchronous clear of statistics and watchdog flag
- PC  out  32  current fetch address
- IFID_Instruction, IFID_PC  out  32 each  IF/ID contents
- IFID_Valid  out  1  IF/ID holds a real instruction
- IDEX_Instruction, IDEX_PC  out  32 each  ID/EX contents
- IDEX_Valid  out  1  ID/EX holds a real instruction
- EXMEM_Bubble, MEMWB_Bubble  out  1 each  registered bubble strobes
- Stall_Count, Flush_Count  out  CNT_W each  saturating statistics
- Stall_Timeout  out  1  sticky watchdog flag

## Operation
- Each cycle is exactly one mode, in priority order:
- FLUSH (PCSrc=1, all other controls ignored): PC <= Branch_Target; IF/ID <= {NOP, 0}, valid 0; ID/EX <= {NOP, 0}, valid 0; Flush_Count++.
- STALL (PCSrc=0, PC_Write=1): PC holds; IF/ID holds (IF_ID_Signal treated as 1 regardless of its value); if ID_EX_Signal=1 ID/EX holds, else ID/EX <= NOP, valid 0 (bubble); Stall_Count++.
- RUN (PCSrc=0, PC_Write=0): PC <= PC+4 (mod 2^32); IF/ID <= {IMem_Instruction, PC}, valid 1; ID/EX <= IF/ID contents including valid. IF_ID_Signal/ID_EX_Signal ignored.
- EXMEM_Bubble <= EX_MEM_Signal; MEMWB_Bubble <= MEM_WB_Signal (all modes).
- Watchdog: 8-bit run counter increments on STALL, clears on FLUSH/RUN; when it reaches MAX_STALL, Stall_Timeout <= 1 and stays set until reset or Clear_Counters. Run counter saturates at MAX_STALL. Does not alter pipeline behaviour.
- Counters saturate at 2^CNT_W-1, never wrap.
- Clear_Counters=1: Stall_Count, Flush_Count, Stall_Timeout, run counter <= 0 at the edge, overriding that cycle's increment; pipeline registers unaffected.

## Timing
- Reset (Reset_n=0, asynchronous): PC=RESET_PC; IF/ID and ID/EX instruction=NOP, PC fields=0, valids=0; bubble strobes=0; counters, run counter, Stall_Timeout=0. Release synchronous to next rising edge; first edge after release is a normal mode cycle.
- Reset asserted mid-stall or mid-flush: all state returns to reset values immediately; no pending redirect survives.
- All outputs registered; controls sampled at rising edge, effect visible the same edge (1-cycle latency).
- PCSrc and PC_Write both 1: FLUSH wins, counts as flush only, run counter clears.
- Branch_Target used unmodified (no alignment).
- Fetch at PC=32'hFFFF_FFFC in RUN: next PC=0.

## Test plan
- Reset then 3 RUN cycles with IMem=A,B,C: PC 0->4->8->C; IFID=C/PC 8, IDEX=B/PC 4, both valid.
- STALL with ID_EX_Signal=0 for 1 cycle: PC and IF/ID hold, IDEX_Valid=0, IDEX_Instruction=NOP, Stall_Count=1.
- STALL with ID_EX_Signal=1 and PC_Write=1, then PCSrc=1 target 0x100 concurrent with PC_Write=1: PC=0x100, both valids 0, Flush_Count=1, Stall_Count unchanged from the preceding stall.
- MAX_STALL=8: 7 consecutive stalls -> Stall_Timeout=0; 8th -> 1; RUN afterwards keeps 1; Clear_Counters clears it and both counters to 0.
- CNT_W=4, 20 flushes -> Flush_Count=15; PC at 0xFFFFFFFC RUN -> 0; assert Reset_n low mid-stall -> outputs reset without clock edge.
